// File: rtl/down_counter_4b_if.sv
// rtl/down_counter_4b_if.sv - control and status bundle for the loadable down-counter
interface down_counter_4b_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic             ld;
    logic             cnt;
    logic             auto;
    logic [WIDTH-1:0] count;
    logic             tcount;
    logic             reload_pulse;

    modport master (
        output in,
        output ld,
        output cnt,
        output auto,
        input  count,
        input  tcount,
        input  reload_pulse
    );

    modport slave (
        input  in,
        input  ld,
        input  cnt,
        input  auto,
        output count,
        output tcount,
        output reload_pulse
    );
endinterface

// File: rtl/down_counter_4b.sv
// rtl/down_counter_4b.sv - loadable down-counter with wrap, auto-reload and terminal count
module down_counter_4b #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    down_counter_4b_if.slave  bus
);
    logic [WIDTH-1:0] r_count;
    logic             r_reload_pulse;
    logic             w_zero;

    assign w_zero = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count        <= '0;
            r_reload_pulse <= 1'b0;
        end else if (bus.ld) begin
            r_count        <= bus.in;
            r_reload_pulse <= 1'b0;
        end else if (bus.cnt) begin
            // At zero: auto mode reloads from in, otherwise wrap to all ones
            if (!w_zero) begin
                r_count        <= r_count - 1'b1;
                r_reload_pulse <= 1'b0;
            end else if (bus.auto) begin
                r_count        <= bus.in;
                r_reload_pulse <= 1'b1;
            end else begin
                r_count        <= '1;
                r_reload_pulse <= 1'b0;
            end
        end else begin
            r_reload_pulse <= 1'b0;
        end
    end

    assign bus.count        = r_count;
    assign bus.tcount       = w_zero;
    assign bus.reload_pulse = r_reload_pulse;
endmodule

// File: tb/tb_down_counter_4b.sv
// tb/tb_down_counter_4b.sv - directed vector bench for down_counter_4b
module tb_down_counter_4b;
    logic clk;
    logic rst;

    down_counter_4b_if #(.WIDTH(4)) bus ();

    down_counter_4b #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic       cnt;
        logic       auto;
        logic [3:0] in;
        logic [3:0] exp_count;
        logic       exp_tc;
        logic       exp_rp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic c, input logic a, input logic [3:0] v);
        @(negedge clk);
        rst      = r;
        bus.ld   = l;
        bus.cnt  = c;
        bus.auto = a;
        bus.in   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [3:0] ec, input logic et, input logic ep);
        check({name, ".count"}, 32'(bus.count), 32'(ec));
        check({name, ".tcount"}, 32'(bus.tcount), 32'(et));
        check({name, ".reload_pulse"}, 32'(bus.reload_pulse), 32'(ep));
    endtask

    initial begin
        logic [3:0] m_count;
        logic       m_rp;

        rst = 1'b1; bus.ld = 1'b0; bus.cnt = 1'b0; bus.auto = 1'b0; bus.in = 4'h0;

        //             name        rst   ld    cnt   auto  in     count  tc    rp
        vecs.push_back('{"reset",   1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"idle0",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"idle1",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"load3",   1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'h3, 1'b0, 1'b0});
        vecs.push_back('{"dec2",    1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{"dec1",    1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{"dec0",    1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"wrap",    1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{"load2",   1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{"auto1",   1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{"auto0",   1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"reload",  1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h2, 1'b0, 1'b1});
        vecs.push_back('{"auto1b",  1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{"auto0b",  1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"load5",   1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 4'h5, 1'b0, 1'b0});
        vecs.push_back('{"ld_wins", 1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 4'h9, 1'b0, 1'b0});
        vecs.push_back('{"hold",    1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'h9, 1'b0, 1'b0});
        vecs.push_back('{"rst_ld",  1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"load4",   1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{"a4_3",    1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 4'h3, 1'b0, 1'b0});
        vecs.push_back('{"a4_2",    1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{"rst_mid", 1'b1, 1'b0, 1'b1, 1'b1, 4'h4, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"post_rl", 1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 4'h4, 1'b0, 1'b1});
        vecs.push_back('{"rp_drop", 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{"load0",   1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{"in0_a",   1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1});
        vecs.push_back('{"in0_b",   1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1});
        vecs.push_back('{"ld_at0",  1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].cnt, vecs[i].auto, vecs[i].in);
            check_all(vecs[i].name, vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_rp);
        end

        // Full descent from 15 then wrap, counting down through every value
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        check_all("loadF", 4'hF, 1'b0, 1'b0);
        m_count = 4'hF;
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h6);
            m_count = (m_count == 4'h0) ? 4'hF : m_count - 4'h1;
            check_all($sformatf("desc%0d", k), m_count, (m_count == 4'h0), 1'b0);
        end

        // Periodic auto-reload with N=3: period of four enabled cycles
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h3);
        check_all("loadN3", 4'h3, 1'b0, 1'b0);
        m_count = 4'h3;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
            m_rp    = (m_count == 4'h0);
            m_count = (m_count == 4'h0) ? 4'h3 : m_count - 4'h1;
            check_all($sformatf("per%0d", k), m_count, (m_count == 4'h0), m_rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/down_counter_4b.md
Name: down_counter_4b

Overview:
- Loadable synchronous down-counter: the decrementing counterpart of the team's 4-bit up-counter, with the same load / count-enable / terminal-count interface.
- Used for delay timers, loop-iteration counters and countdown-to-zero control in datapath designs.
- Optional auto-reload turns it into a periodic divider/timer.
- Terminal count flags zero so controller FSMs can branch on "done".

Parameters:
- WIDTH, 4, counter width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- count  output  WIDTH  current counter value (registered).
- tcount  output  1  terminal count; 1 when count == 0 (combinational decode of the count register).
- reload_pulse  output  1  registered; 1 for exactly one cycle following an auto-reload event.
- in  input  WIDTH  parallel load value; also the auto-reload value.
- ld  input  1  parallel load enable.
- cnt  input  1  count (decrement) enable.
- auto  input  1  auto-reload mode select.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk only.
- Reset (rst=1 at an edge): count <= 0, reload_pulse <= 0. tcount is therefore 1 after reset. rst has the highest priority and overrides ld, cnt and auto.
- Priority at each rising edge (rst=0): ld > cnt > hold.
- ld=1: count <= in. reload_pulse <= 0. cnt and auto are ignored in that cycle.
- ld=0, cnt=1, count != 0: count <= count - 1. reload_pulse <= 0.
- ld=0, cnt=1, count == 0, auto=0: wrap; count <= all ones (2^WIDTH - 1). reload_pulse <= 0.
- ld=0, cnt=1, count == 0, auto=1: reload; count <= in. reload_pulse <= 1.
- ld=0, cnt=0: count holds its value. reload_pulse <= 0.
- tcount = (count == 0).
  - Purely a decode of the register: no dependence on cnt, ld or auto.
  - Valid in the same cycle count reaches 0.
- Latency:
  - Load: count reflects in one edge after ld is sampled.
  - Decrement: one edge per enabled cycle.
  - tcount: zero cycles after count changes.
- Period in auto mode with constant in=N and cnt held high: count sequence N, N-1, …, 0, N, …; period N+1 cycles.
- Auto mode with in=0: count stays 0, tcount stays 1, and reload_pulse is 1 on every enabled cycle.
- Inputs change only away from the rising edge (bench drives on the falling half); no metastability handling required.
- Reset mid-count: count is forced to 0 at the next edge regardless of any in-progress sequence; counting resumes only after rst deasserts.
- Arithmetic is unsigned modulo 2^WIDTH. There are no outputs other than those listed.

Test Plan:
- Reset: rst=1 for one edge -> count=0000, tcount=1, reload_pulse=0. Then rst=0, cnt=0 for two edges -> count stays 0000, tcount=1.
- Load and decrement: ld=1, in=0011 for one edge -> count=0011, tcount=0. Then ld=0, cnt=1 for three edges -> count 0010, 0001, 0000; tcount=1 only at 0000.
- Wrap without auto: from count=0000 with cnt=1, auto=0, one edge -> count=1111, tcount=0, reload_pulse=0.
- Auto-reload: load in=0010, then cnt=1, auto=1 for five edges -> count 0001, 0000, 0010, 0001, 0000; reload_pulse=1 only in the cycle after the 0000->0010 transition.
- Priority and hold:
  - count=0101, ld=1, cnt=1, in=1001 -> count=1001 (load wins).
  - Next edge with cnt=0 -> count holds at 1001.
  - rst=1 together with ld=1 -> count=0000.
- Reset mid-operation: while auto-reloading with in=0100 and count=0010, assert rst for one edge -> count=0000, reload_pulse=0. After rst deasserts with cnt=1, auto=1 -> count=0100 and reload_pulse=1 on the next edge.
